// File: rtl/exc_ctrl_pkg.sv
// ============================================================================
// Module      : exc_ctrl_pkg
// Description : Shared types and constants for the exception controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package exc_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_COMMIT = 2'd2,
        ST_REDIR  = 2'd3
    } state_t;

    typedef enum logic {
        KIND_EXC  = 1'b0,
        KIND_ERET = 1'b1
    } kind_t;

    localparam logic [4:0]  EXC_INT    = 5'd0;
    localparam logic [4:0]  EXC_ADEL   = 5'd4;
    localparam logic [4:0]  EXC_ADES   = 5'd5;
    localparam logic [4:0]  EXC_SYS    = 5'd8;
    localparam logic [4:0]  EXC_BP     = 5'd9;
    localparam logic [4:0]  EXC_RI     = 5'd10;
    localparam logic [4:0]  EXC_OV     = 5'd12;
    localparam logic [31:0] EXC_VECTOR = 32'hBFC0_0380;

    typedef struct packed {
        logic        we;
        logic        bd;
        logic        exl;
        logic [4:0]  exc;
        logic [31:0] epc;
        logic [31:0] bva;
    } reg_error;

    // Only address errors carry a meaningful bad virtual address.
    function automatic logic is_addr_exc(input logic [4:0] code);
        return (code == EXC_ADEL) || (code == EXC_ADES);
    endfunction

endpackage

`default_nettype wire

// File: rtl/exc_ctrl.sv
// ============================================================================
// Module      : exc_ctrl
// Description : Precise exception / interrupt / ERET sequencer driving CP0.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module exc_ctrl
    import exc_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        exc_req,
    input  logic [4:0]  exc_code,
    input  logic [31:0] exc_pc,
    input  logic        exc_bd,
    input  logic [31:0] exc_bva,
    input  logic        eret_req,
    input  logic [7:0]  intr_vect,
    input  logic [31:0] int_pc,
    input  logic        int_bd,
    input  logic        mem_busy,
    output reg_error    cp0w,
    output logic        hold,
    output logic        flush,
    output logic        redir_valid,
    output logic [31:0] redir_pc
);

    state_t      r_state,   w_state_nxt;
    kind_t       r_kind,    w_kind_nxt;
    logic [4:0]  r_code,    w_code_nxt;
    logic [31:0] r_pc,      w_pc_nxt;
    logic        r_bd,      w_bd_nxt;
    logic [31:0] r_bva,     w_bva_nxt;

    logic        r_sh_exl;
    logic [4:0]  r_sh_code;
    logic [31:0] r_sh_epc;
    logic        r_sh_bd;
    logic [31:0] r_sh_bva;

    reg_error    r_cp0w,    w_cp0w_nxt;
    logic        r_hold,    w_hold_nxt;
    logic        r_redir,   w_redir_nxt;
    logic [31:0] r_rpc,     w_rpc_nxt;
    logic        w_win;

    always_comb begin
        w_state_nxt = r_state;
        w_kind_nxt  = r_kind;
        w_code_nxt  = r_code;
        w_pc_nxt    = r_pc;
        w_bd_nxt    = r_bd;
        w_bva_nxt   = r_bva;
        w_win       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (exc_req) begin
                    w_win      = 1'b1;
                    w_kind_nxt = KIND_EXC;
                    w_code_nxt = exc_code;
                    w_pc_nxt   = exc_pc;
                    w_bd_nxt   = exc_bd;
                    w_bva_nxt  = exc_bva;
                end else if ((intr_vect != 8'd0) && !r_sh_exl) begin
                    w_win      = 1'b1;
                    w_kind_nxt = KIND_EXC;
                    w_code_nxt = EXC_INT;
                    w_pc_nxt   = int_pc;
                    w_bd_nxt   = int_bd;
                    w_bva_nxt  = r_sh_bva;
                end else if (eret_req) begin
                    w_win      = 1'b1;
                    w_kind_nxt = KIND_ERET;
                    w_code_nxt = 5'd0;
                    w_pc_nxt   = 32'd0;
                    w_bd_nxt   = 1'b0;
                    w_bva_nxt  = 32'd0;
                end
                if (w_win) begin
                    w_state_nxt = mem_busy ? ST_DRAIN : ST_COMMIT;
                end
            end
            ST_DRAIN:  if (!mem_busy) w_state_nxt = ST_COMMIT;
            ST_COMMIT: w_state_nxt = ST_REDIR;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // Outputs are computed one state ahead so they can be registered.
    always_comb begin
        w_cp0w_nxt  = '0;
        w_hold_nxt  = (w_state_nxt != ST_IDLE);
        w_redir_nxt = (w_state_nxt == ST_REDIR);
        w_rpc_nxt   = 32'd0;
        if (w_state_nxt == ST_COMMIT) begin
            w_cp0w_nxt.we = 1'b1;
            if (w_kind_nxt == KIND_ERET) begin
                w_cp0w_nxt.exl = 1'b0;
                w_cp0w_nxt.exc = r_sh_code;
                w_cp0w_nxt.epc = r_sh_epc;
                w_cp0w_nxt.bd  = r_sh_bd;
                w_cp0w_nxt.bva = r_sh_bva;
            end else begin
                w_cp0w_nxt.exl = 1'b1;
                w_cp0w_nxt.exc = w_code_nxt;
                w_cp0w_nxt.epc = r_sh_exl ? r_sh_epc : w_pc_nxt;
                w_cp0w_nxt.bd  = r_sh_exl ? r_sh_bd  : w_bd_nxt;
                w_cp0w_nxt.bva = is_addr_exc(w_code_nxt) ? w_bva_nxt : r_sh_bva;
            end
        end
        if (w_state_nxt == ST_REDIR) begin
            w_rpc_nxt = (w_kind_nxt == KIND_ERET) ? r_sh_epc : EXC_VECTOR;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_kind    <= KIND_EXC;
            r_code    <= 5'd0;
            r_pc      <= 32'd0;
            r_bd      <= 1'b0;
            r_bva     <= 32'd0;
            r_sh_exl  <= 1'b0;
            r_sh_code <= 5'd0;
            r_sh_epc  <= 32'd0;
            r_sh_bd   <= 1'b0;
            r_sh_bva  <= 32'd0;
            r_cp0w    <= '0;
            r_hold    <= 1'b0;
            r_redir   <= 1'b0;
            r_rpc     <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            r_kind  <= w_kind_nxt;
            r_code  <= w_code_nxt;
            r_pc    <= w_pc_nxt;
            r_bd    <= w_bd_nxt;
            r_bva   <= w_bva_nxt;
            if (r_cp0w.we) begin
                r_sh_exl  <= r_cp0w.exl;
                r_sh_code <= r_cp0w.exc;
                r_sh_epc  <= r_cp0w.epc;
                r_sh_bd   <= r_cp0w.bd;
                r_sh_bva  <= r_cp0w.bva;
            end
            r_cp0w  <= w_cp0w_nxt;
            r_hold  <= w_hold_nxt;
            r_redir <= w_redir_nxt;
            r_rpc   <= w_rpc_nxt;
        end
    end

    assign cp0w        = r_cp0w;
    assign hold        = r_hold;
    assign flush       = r_redir;
    assign redir_valid = r_redir;
    assign redir_pc    = r_rpc;

endmodule

`default_nettype wire

// File: doc/exc_ctrl.md
EXC_CTRL -- requirements
Module: exc_ctrl

Interface
REQ-001 SHALL run on one clock; reset is synchronous and active-low.
REQ-002 clk  in  1  system clock, all state updates on rising edge.
REQ-003 rst  in  1  synchronous active-low reset.
REQ-004 exc_req  in  1  pipeline reports a precise exception this cycle.
REQ-005 exc_code  in  5  ExcCode of the faulting instruction.
REQ-006 exc_pc  in  32  PC of the faulting instruction (or of the branch, if in a delay slot).
REQ-007 exc_bd  in  1  faulting instruction is in a branch delay slot.
REQ-008 exc_bva  in  32  bad virtual address; meaningful for AdEL/AdES only.
REQ-009 eret_req  in  1  ERET has reached commit.
REQ-010 intr_vect  in  8  pending-and-enabled interrupt lines from CP0.
REQ-011 int_pc  in  32  restart PC for an interrupt taken at commit.
REQ-012 int_bd  in  1  restart instruction is in a delay slot.
REQ-013 mem_busy  in  1  memory stage has an outstanding access and cannot be flushed yet.
REQ-014 cp0w  out  reg_error  CP0 exception-state write (we, bd, exl, exc, epc, bva).
REQ-015 hold  out  1  freeze the pipeline.
REQ-016 flush  out  1  kill all in-flight instructions.
REQ-017 redir_valid  out  1  one-cycle PC redirect strobe.
REQ-018 redir_pc  out  32  redirect target.

Function
REQ-019 States: IDLE, DRAIN, COMMIT, REDIR; transitions are evaluated only on rising edges.
REQ-020 Request sampling in IDLE uses the priority exc_req > interrupt (intr_vect != 0 and exl_q == 0) > eret_req; the winner is latched into pending registers (kind, code, pc, bd, bva).
REQ-021 The interrupt winner latches code 0, int_pc and int_bd, and bva = shadow bva.
REQ-022 From IDLE with a winner: go to DRAIN if mem_busy = 1, else go to COMMIT.
REQ-023 DRAIN holds until mem_busy = 0, then goes to COMMIT; there is no timeout.
REQ-024 hold = 1 in DRAIN, COMMIT and REDIR; hold = 0 in IDLE.
REQ-025 Requests arriving outside IDLE are ignored; the requester keeps them asserted under hold.
REQ-026 COMMIT (exception or interrupt) drives cp0w.we = 1 for exactly one cycle.
REQ-027 In that exception/interrupt COMMIT: exl = 1 and exc = the pending code.
REQ-028 If exl_q was 0: epc = pending pc and bd = pending bd.
REQ-029 If exl_q was 1: epc and bd are rewritten from the shadow registers, so they stay unchanged.
REQ-030 In that exception/interrupt COMMIT: bva = pending bva for codes 4/5, otherwise the shadow bva.
REQ-031 ERET COMMIT drives cp0w.we = 1 with exl = 0, and exc/epc/bd/bva from the shadows, so only EXL changes.
REQ-032 Shadow registers (exl_q, code, epc, bd, bva) update on every cycle with cp0w.we = 1 and mirror what CP0 holds.
REQ-033 COMMIT always goes to REDIR.
REQ-034 REDIR asserts flush = 1 and redir_valid = 1 for one cycle, then returns to IDLE.
REQ-035 redir_pc = 32'hBFC0_0380 for exceptions and interrupts; redir_pc = shadow epc for ERET.
REQ-036 End-to-end latency (no drain): request at cycle N, cp0w.we at N+1, redirect at N+2, hold released at N+3.
REQ-037 Outside COMMIT, cp0w.we = 0 and all other cp0w fields = 0.
REQ-038 Outside REDIR, flush = 0, redir_valid = 0 and redir_pc = 0.

Reset
REQ-039 rst = 0 at a clock edge forces state IDLE and clears all pending and shadow registers to 0; exl_q = 0.
REQ-040 On that reset all outputs are 0 in the following cycle, including mid-DRAIN or mid-COMMIT; an aborted CP0 write is not replayed.

Structure
REQ-041 The state enum, the ExcCode constants (Int = 0, AdEL = 4, AdES = 5, Sys = 8, Bp = 9, RI = 10, Ov = 12) and EXC_VECTOR = 32'hBFC0_0380 live in the shared defines/package beside reg_error.
REQ-042 The design is a single module with no sub-module; the priority pick is inline combinational logic.

Verification
REQ-043 IDLE, exc_req with code 12 and pc 0x8000_0100, mem_busy = 0: cp0w.we at +1 (exl = 1, exc = 12, epc = 0x8000_0100), then flush/redir to 0xBFC0_0380 at +2.
REQ-044 Same request with mem_busy = 1 for 3 cycles: hold = 1 throughout, cp0w.we exactly 1 cycle after mem_busy falls, no early flush.
REQ-045 exc_req (code 4, bva 0x1234_5671) and intr_vect = 8'h04 in the same cycle: the exception wins with exc = 4 and bva = 0x1234_5671; the interrupt is not taken while exl_q = 1.
REQ-046 After entry with epc 0x8000_0200, a second exception with code 8: epc stays 0x8000_0200 and exc = 8.
REQ-047 Then ERET: cp0w exl = 0, epc = 0x8000_0200, and redir_pc = 0x8000_0200.
REQ-048 rst low during DRAIN: next cycle all outputs = 0 and state = IDLE; a subsequent interrupt commits with epc = int_pc.
